// File: rtl/inst_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_stage
// Purpose  : Instruction-fetch stage of a 5-stage MIPS pipeline. Holds the PC,
//            issues instruction-memory requests over a req/ack handshake,
//            buffers the returned word when decode cannot take it, and drives
//            the IF/ID pipeline register. Applies stall, flush and redirect.
// Ports    : clk, rst (async, active-high)
//            cpu_en, if_stall, redirect_en, redirect_target  - control in
//            imem_req, imem_addr / imem_ack, imem_data       - memory side
//            id_valid, id_inst, id_pc, id_pc_next            - IF/ID register
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        if_stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_next
);

    localparam logic [31:0] c_PC_RESET_ALIGNED = PC_RESET & ~32'h3;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] req_addr_q,   req_addr_d;
    logic        kill_q,       kill_d;
    logic [31:0] hold_inst_q,  hold_inst_d;
    logic [31:0] hold_pc_q,    hold_pc_d;
    logic        id_valid_q,   id_valid_d;
    logic [31:0] id_inst_q,    id_inst_d;
    logic [31:0] id_pc_q,      id_pc_d;
    logic [31:0] id_pc_next_q, id_pc_next_d;

    logic        w_acc;
    logic        w_deliver;
    logic [31:0] w_tgt;
    logic [31:0] w_addr_inc;
    logic [31:0] w_hold_inc;

    assign w_acc      = cpu_en & ~if_stall & ~redirect_en;
    assign w_tgt      = redirect_target & ~32'h3;
    assign w_addr_inc = req_addr_q + 32'd4;
    assign w_hold_inc = hold_pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        kill_d       = kill_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        id_valid_d   = id_valid_q;
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;
        w_deliver    = 1'b0;

        if (cpu_en && redirect_en) begin
            pc_d       = w_tgt;
            state_d    = S_REQ;
            id_valid_d = 1'b0;
            id_inst_d  = 32'h0;
            if (state_q == S_REQ && !imem_ack) begin
                // The outstanding request cannot be withdrawn; remember to
                // discard its data and re-issue at the new pc afterwards.
                kill_d = 1'b1;
            end else begin
                // Any ack this cycle belongs to the squashed path.
                req_addr_d = w_tgt;
                kill_d     = 1'b0;
            end
        end else if (state_q == S_REQ) begin
            if (imem_ack && kill_q) begin
                kill_d     = 1'b0;
                req_addr_d = pc_q;
            end else if (imem_ack && !cpu_en) begin
                // Frozen: park the word; pc advances when it is released.
                hold_inst_d = imem_data;
                hold_pc_d   = req_addr_q;
                state_d     = S_HOLD;
            end else if (imem_ack) begin
                pc_d       = w_addr_inc;
                req_addr_d = w_addr_inc;
                if (w_acc) begin
                    w_deliver    = 1'b1;
                    id_valid_d   = 1'b1;
                    id_inst_d    = imem_data;
                    id_pc_d      = req_addr_q;
                    id_pc_next_d = w_addr_inc;
                end else begin
                    hold_inst_d = imem_data;
                    hold_pc_d   = req_addr_q;
                    state_d     = S_HOLD;
                end
            end
        end else if (w_acc) begin
            // Releasing the buffer: derive the next fetch from the buffered
            // pc so a word captured while frozen is neither lost nor repeated.
            w_deliver    = 1'b1;
            id_valid_d   = 1'b1;
            id_inst_d    = hold_inst_q;
            id_pc_d      = hold_pc_q;
            id_pc_next_d = w_hold_inc;
            pc_d         = w_hold_inc;
            req_addr_d   = w_hold_inc;
            state_d      = S_REQ;
        end

        if (w_acc && !w_deliver) begin
            id_valid_d = 1'b0;
            id_inst_d  = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= c_PC_RESET_ALIGNED;
            req_addr_q   <= c_PC_RESET_ALIGNED;
            kill_q       <= 1'b0;
            hold_inst_q  <= 32'h0;
            hold_pc_q    <= 32'h0;
            id_valid_q   <= 1'b0;
            id_inst_q    <= 32'h0;
            id_pc_q      <= 32'h0;
            id_pc_next_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            kill_q       <= kill_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            id_valid_q   <= id_valid_d;
            id_inst_q    <= id_inst_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
        end
    end

    // Gated by rst so the request drops the instant reset is asserted.
    assign imem_req   = ~rst & (state_q == S_REQ);
    assign imem_addr  = req_addr_q;
    assign id_valid   = id_valid_q;
    assign id_inst    = id_inst_q;
    assign id_pc      = id_pc_q;
    assign id_pc_next = id_pc_next_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_stage
// Purpose  : Directed self-checking bench for inst_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic        if_stall;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;

    int n_cmp = 0;
    int n_err = 0;

    inst_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_en          (cpu_en),
        .if_stall        (if_stall),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_pc_next      (id_pc_next)
    );

    always #5 clk = ~clk;

    // Instruction memory contents seen by the bench.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   mem = 32'h2001_0005;
            32'h4:   mem = 32'h2002_0003;
            default: mem = 32'h8C00_0000 ^ a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        imem_ack = 1'b0; redirect_en = 1'b0; if_stall = 1'b0; cpu_en = 1'b1;
    endtask

    task automatic ack(input logic [31:0] a);
        imem_ack = 1'b1; imem_data = mem(a);
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b1; if_stall = 1'b0; redirect_en = 1'b0;
        redirect_target = 32'h0; imem_ack = 1'b0; imem_data = 32'h0;
        tick(); tick();
        chk("rst_req",      {31'b0, imem_req},  32'h0);
        chk("rst_valid",    {31'b0, id_valid},  32'h0);
        chk("rst_inst",     id_inst,            32'h0);
        chk("rst_pc",       id_pc,              32'h0);
        chk("rst_pc_next",  id_pc_next,         32'h0);
        rst = 1'b0; #1;
        chk("first_req",    {31'b0, imem_req},  32'h1);
        chk("first_addr",   imem_addr,          32'h0);

        // Zero-wait straight-line fetch.
        ack(32'h0); tick();
        chk("f0_valid",  {31'b0, id_valid}, 32'h1);
        chk("f0_inst",   id_inst,           32'h2001_0005);
        chk("f0_pc",     id_pc,             32'h0);
        chk("f0_pcn",    id_pc_next,        32'h4);
        chk("f0_addr",   imem_addr,         32'h4);
        ack(32'h4); tick();
        chk("f1_inst",   id_inst,           32'h2002_0003);
        chk("f1_pc",     id_pc,             32'h4);
        chk("f1_addr",   imem_addr,         32'h8);

        // Stall for 3 cycles while the ack for 8 arrives.
        if_stall = 1'b1; ack(32'h8); tick();
        chk("st0_req",   {31'b0, imem_req}, 32'h0);
        chk("st0_pc",    id_pc,             32'h4);
        chk("st0_valid", {31'b0, id_valid}, 32'h1);
        imem_ack = 1'b0; tick();
        chk("st1_req",   {31'b0, imem_req}, 32'h0);
        chk("st1_pc",    id_pc,             32'h4);
        tick();
        chk("st2_pc",    id_pc,             32'h4);
        if_stall = 1'b0; tick();
        chk("rel_pc",    id_pc,             32'h8);
        chk("rel_inst",  id_inst,           mem(32'h8));
        chk("rel_pcn",   id_pc_next,        32'hC);
        chk("rel_req",   {31'b0, imem_req}, 32'h1);
        chk("rel_addr",  imem_addr,         32'hC);
        ack(32'hC); tick();
        chk("f12_pc",    id_pc,             32'hC);
        chk("f12_addr",  imem_addr,         32'h10);

        // Redirect to 0x43 while a 2-wait request for 16 is outstanding.
        idle(); redirect_en = 1'b1; redirect_target = 32'h0000_0043; tick();
        chk("rd0_addr",  imem_addr,         32'h10);
        chk("rd0_req",   {31'b0, imem_req}, 32'h1);
        chk("rd0_valid", {31'b0, id_valid}, 32'h0);
        chk("rd0_inst",  id_inst,           32'h0);
        chk("rd0_pc",    id_pc,             32'hC);
        idle(); tick();
        chk("rd1_addr",  imem_addr,         32'h10);
        ack(32'h10); tick();
        chk("rd2_valid", {31'b0, id_valid}, 32'h0);
        chk("rd2_addr",  imem_addr,         32'h40);
        ack(32'h40); tick();
        chk("rd3_valid", {31'b0, id_valid}, 32'h1);
        chk("rd3_pc",    id_pc,             32'h40);
        chk("rd3_inst",  id_inst,           mem(32'h40));
        chk("rd3_addr",  imem_addr,         32'h44);

        // Redirect and stall together, with an ack that must be dropped.
        if_stall = 1'b1; redirect_en = 1'b1; redirect_target = 32'h100; ack(32'h44); tick();
        chk("rs_valid",  {31'b0, id_valid}, 32'h0);
        chk("rs_inst",   id_inst,           32'h0);
        chk("rs_pc",     id_pc,             32'h40);
        chk("rs_addr",   imem_addr,         32'h100);
        idle(); ack(32'h100); tick();
        chk("rs1_pc",    id_pc,             32'h100);
        chk("rs1_inst",  id_inst,           mem(32'h100));

        // cpu_en low for 2 cycles around an outstanding request.
        idle(); cpu_en = 1'b0; tick();
        chk("ce0_req",   {31'b0, imem_req}, 32'h1);
        chk("ce0_addr",  imem_addr,         32'h104);
        chk("ce0_pc",    id_pc,             32'h100);
        cpu_en = 1'b0; ack(32'h104); tick();
        chk("ce1_pc",    id_pc,             32'h100);
        chk("ce1_req",   {31'b0, imem_req}, 32'h0);
        idle(); tick();
        chk("ce2_pc",    id_pc,             32'h104);
        chk("ce2_inst",  id_inst,           mem(32'h104));
        chk("ce2_addr",  imem_addr,         32'h108);
        ack(32'h108); tick();
        chk("ce3_pc",    id_pc,             32'h108);

        // PC wrap.
        idle(); redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFC; ack(32'h10C); tick();
        chk("wr0_addr",  imem_addr,         32'hFFFF_FFFC);
        chk("wr0_valid", {31'b0, id_valid}, 32'h0);
        idle(); ack(32'hFFFF_FFFC); tick();
        chk("wr1_pc",    id_pc,             32'hFFFF_FFFC);
        chk("wr1_pcn",   id_pc_next,        32'h0);
        chk("wr1_addr",  imem_addr,         32'h0);

        // Asynchronous reset mid-request, with a late ack during reset.
        idle(); #1; rst = 1'b1; #1;
        chk("ar_req",    {31'b0, imem_req}, 32'h0);
        chk("ar_valid",  {31'b0, id_valid}, 32'h0);
        chk("ar_pc",     id_pc,             32'h0);
        ack(32'h0); tick();
        chk("ar1_valid", {31'b0, id_valid}, 32'h0);
        imem_ack = 1'b0; rst = 1'b0; #1;
        chk("ar2_req",   {31'b0, imem_req}, 32'h1);
        chk("ar2_addr",  imem_addr,         32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
